scan_history: RTL
=================

Name: scan_history

Overview:
- Parametrised successor to the fixed four-byte scan-code history display.
- Sits between the PS/2 keyboard receiver and consumers such as the hex display driver and game input logic.
- Edge-detects `scan_ready` internally and issues the `read` acknowledge itself, so no external oneshot is needed.
- Decodes E0/F0 prefixes into complete key events and keeps a DEPTH-entry history of decoded events, not raw bytes.

Parameters:
- DEPTH, 4, number of history entries (1..16).
- CW, $clog2(DEPTH+1), width of hist_count (derived; do not override).

Ports:
- clock50  in  1  system clock, 50 MHz; everything is on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- scan_ready  in  1  level from the PS/2 receiver; high while a byte is pending.
- scan_code  in  8  byte from the receiver; valid while scan_ready is high.
- read  out  1  one-cycle acknowledge pulse to the receiver.
- clear  in  1  synchronous clear of the history.
- ev_valid  out  1  one-cycle pulse when an event completes.
- ev_code  out  8  final (non-prefix) byte of the event.
- ev_ext  out  1  event was prefixed by E0.
- ev_break  out  1  event was prefixed by F0 (key release).
- history  out  10*DEPTH  entry i at [10*i+9:10*i] = {ext, break, code}; entry 0 is newest.
- hist_count  out  CW  number of valid entries, 0..DEPTH; saturates.
- dropped  out  1  sticky flag: an entry has been shifted out past DEPTH.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - All outputs go to 0: read, ev_valid, ev_code, ev_ext, ev_break, history, hist_count, dropped.
  - Decoder goes to IDLE; the edge-detect register is set to 0.
- Byte acceptance:
  - rdy_q is a registered copy of scan_ready. A byte is accepted in cycle T when scan_ready=1 and rdy_q=0.
  - scan_code is captured in T. read is 1 in T+1 only.
  - A level held high does not cause a second accept. A new accept needs scan_ready to fall and rise again.
- Decoder FSM (advances only on an accept):
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> emit {0,0,code}, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> emit {1,0,code}, go to IDLE.
  - BRK: E0 -> EXT_BRK (tolerated ordering); F0 -> stay BRK; other -> emit {0,1,code}, go to IDLE.
  - EXT_BRK: E0/F0 -> stay; other -> emit {1,1,code}, go to IDLE.
  - E1, AA, FA, FE are ordinary bytes; no special handling.
- Emit:
  - ev_valid=1 in T+1, with ev_code/ev_ext/ev_break valid that same cycle. ev_* hold their values until the next emit.
  - In T+1: history shifts up one entry, entry 0 takes the new event, hist_count increments and saturates at DEPTH.
  - If hist_count==DEPTH before the shift, the oldest entry is lost and dropped is set.
- Latency: accept-to-event and accept-to-read are both exactly 1 cycle. Prefix bytes produce read but no ev_valid.
- clear=1:
  - history, hist_count and dropped go to 0 on the next edge.
  - The decoder state is kept, so a split sequence still completes.
  - If clear and an emit land on the same edge, clear wins for storage: the history stays empty, but ev_valid/ev_* still fire.
- Reset mid-prefix: the decoder returns to IDLE and the partial prefix is discarded.

Optional Feature:
- Macro: SCAN_HISTORY_TYPEMATIC_FILTER_EN.
- Defined: a make event is suppressed when all of these hold:
  - hist_count>0;
  - entry 0 is a make (break=0);
  - entry 0 has the same {ext, code} as the new event.
  - A suppressed event produces no ev_valid and no history change. read is still pulsed.
- Undefined: every completed event is emitted and stored, including auto-repeat.

Test Plan:
- Reset, then feed 1C, F0, 1C -> two ev_valid pulses; history[9:0]=0x11C, history[19:10]=0x01C; hist_count=2.
- Feed E0, F0, 75 -> one ev_valid; ev_ext=1, ev_break=1, ev_code=0x75; read pulses 3 times, each 1 cycle after its accept.
- DEPTH=4, feed 5 plain codes 01..05 -> history newest-first is 05, 04, 03, 02; hist_count=4; dropped=1. Then pulse clear -> all 0.
- Hold scan_ready high for 10 cycles with 0x2D -> exactly one read and one event. clear coincident with a later emit -> ev_valid=1, hist_count stays 0.
- Feed E0, pulse resetn low for 1 cycle, then feed 6B -> event {0,0,6B}; the prefix is not retained.
- With SCAN_HISTORY_TYPEMATIC_FILTER_EN defined, feed 1D, 1D, 1D, F0, 1D -> ev_valid count 2; hist_count=2. Without the macro -> count 4, hist_count=4.

Source files
------------

// File: rtl/scan_history.sv
// PS/2 scan-code history: decodes E0/F0 prefixes into key events and keeps the DEPTH newest, newest first.
// Latency: read and ev_valid both come 1 cycle after a byte is accepted. Optional: SCAN_HISTORY_TYPEMATIC_FILTER_EN.
// Backpressure: none; a byte is taken on each scan_ready rising edge and acknowledged with read.
module scan_history #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clock50,
  input  logic                  resetn,
  input  logic                  scan_ready,
  input  logic [7:0]            scan_code,
  output logic                  read,
  input  logic                  clear,
  output logic                  ev_valid,
  output logic [7:0]            ev_code,
  output logic                  ev_ext,
  output logic                  ev_break,
  output logic [10*DEPTH-1:0]   history,
  output logic [CW-1:0]         hist_count,
  output logic                  dropped
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t state_q, state_d;
  logic   rdy_q;
  logic   accept;
  logic   emit;
  logic   emit_ext;
  logic   emit_brk;
  logic   suppress;
  logic   store;

  assign accept = scan_ready && !rdy_q;

  always_ff @(posedge clock50) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_ext = (state_q == EXT) || (state_q == EXT_BRK);
    emit_brk = (state_q == BRK) || (state_q == EXT_BRK);
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (scan_code == 8'hE0)      state_d = EXT;
          else if (scan_code == 8'hF0) state_d = BRK;
          else                         emit    = 1'b1;
        end
        EXT: begin
          if (scan_code == 8'hF0)      state_d = EXT_BRK;
          else if (scan_code != 8'hE0) begin
            emit    = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          // E0 after F0 is out of order on the wire but still means an extended release
          if (scan_code == 8'hE0)      state_d = EXT_BRK;
          else if (scan_code != 8'hF0) begin
            emit    = 1'b1;
            state_d = IDLE;
          end
        end
        EXT_BRK: begin
          if (scan_code != 8'hE0 && scan_code != 8'hF0) begin
            emit    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef SCAN_HISTORY_TYPEMATIC_FILTER_EN
  // Auto-repeat makes of the key already at the head of the history are dropped
  assign suppress = !emit_brk && (hist_count != '0) && !history[8] &&
                    (history[9] == emit_ext) && (history[7:0] == scan_code);
`else
  assign suppress = 1'b0;
`endif

  assign store = emit && !suppress;

  always_ff @(posedge clock50) begin
    if (!resetn) begin
      rdy_q      <= 1'b0;
      read       <= 1'b0;
      ev_valid   <= 1'b0;
      ev_code    <= '0;
      ev_ext     <= 1'b0;
      ev_break   <= 1'b0;
      history    <= '0;
      hist_count <= '0;
      dropped    <= 1'b0;
    end else begin
      rdy_q    <= scan_ready;
      read     <= accept;
      ev_valid <= store;
      if (store) begin
        ev_code  <= scan_code;
        ev_ext   <= emit_ext;
        ev_break <= emit_brk;
      end
      if (clear) begin
        history    <= '0;
        hist_count <= '0;
        dropped    <= 1'b0;
      end else if (store) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          history[10*i +: 10] <= history[10*(i-1) +: 10];
        end
        history[9:0] <= {emit_ext, emit_brk, scan_code};
        if (hist_count == CW'(DEPTH)) dropped    <= 1'b1;
        else                          hist_count <= hist_count + CW'(1);
      end
    end
  end

endmodule
